// File: rtl/sensor_adc_reader.sv
// Periodically scans three channels of an SPI ADC and holds the latest
// 10-bit result of each channel, zero-extended to 16 bits.
module sensor_adc_reader #(
   parameter int unsigned CLK_DIV  = 25,
   parameter int unsigned SCAN_GAP = 1000,
   parameter logic [2:0]  CH1      = 3'd0,
   parameter logic [2:0]  CH2      = 3'd1,
   parameter logic [2:0]  CH3      = 3'd2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        miso,
   output logic        cs_n,
   output logic        sclk,
   output logic        mosi,
   output logic [15:0] sen_1,
   output logic [15:0] sen_2,
   output logic [15:0] sen_3,
   output logic        scan_done,
   output logic        busy,
   output logic [7:0]  scan_count
);

   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

   localparam logic [19:0] DIV_LAST = 20'(CLK_DIV - 1);
   localparam logic [19:0] GAP_LAST = 20'(SCAN_GAP - 1);

   state_t      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [4:0]  bit_q, bit_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] tx_q, tx_d;
   logic [9:0]  rx_q, rx_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic [15:0] sen_1_q, sen_1_d;
   logic [15:0] sen_2_q, sen_2_d;
   logic [15:0] sen_3_q, sen_3_d;
   logic        scan_done_q, scan_done_d;
   logic [7:0]  scan_count_q, scan_count_d;
   logic        load_tx;

   function automatic logic [23:0] tx_word(input logic [1:0] idx);
      logic [2:0] ch;
      ch = (idx == 2'd0) ? CH1 : (idx == 2'd1) ? CH2 : CH3;
      return {7'b0, 1'b1, 1'b1, ch, 12'b0};
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      idx_d        = idx_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      cs_n_d       = cs_n_q;
      sclk_d       = sclk_q;
      mosi_d       = mosi_q;
      sen_1_d      = sen_1_q;
      sen_2_d      = sen_2_q;
      sen_3_d      = sen_3_q;
      scan_done_d  = 1'b0;
      scan_count_d = scan_count_q;
      load_tx      = 1'b0;

      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (enable) begin
               state_d = CS_SETUP;
               idx_d   = 2'd0;
               cnt_d   = '0;
               cs_n_d  = 1'b0;
               load_tx = 1'b1;
            end
         end
         CS_SETUP: begin
            if (cnt_q == DIV_LAST) begin
               state_d = SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[8:0], miso};
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         SHIFT: begin
            if (cnt_q != DIV_LAST) begin
               cnt_d = cnt_q + 20'd1;
            end else begin
               cnt_d = '0;
               if (sclk_q) begin
                  // rotate rather than shift so every tx bit stays in use; after 24 falls mosi returns to bit 23 (0)
                  sclk_d = 1'b0;
                  tx_d   = {tx_q[22:0], tx_q[23]};
                  mosi_d = tx_d[23];
               end else if (bit_q == 5'd23) begin
                  state_d = CS_HOLD;
                  cs_n_d  = 1'b1;
                  mosi_d  = 1'b0;
                  case (idx_q)
                     2'd0:    sen_1_d = {6'b0, rx_q};
                     2'd1:    sen_2_d = {6'b0, rx_q};
                     default: begin
                        sen_3_d      = {6'b0, rx_q};
                        scan_done_d  = 1'b1;
                        scan_count_d = scan_count_q + 8'd1;
                     end
                  endcase
               end else begin
                  bit_d  = bit_q + 5'd1;
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[8:0], miso};
               end
            end
         end
         CS_HOLD: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (!enable) begin
                  state_d = IDLE;
                  idx_d   = 2'd0;
               end else if (idx_q != 2'd2) begin
                  state_d = CS_SETUP;
                  idx_d   = idx_q + 2'd1;
                  cs_n_d  = 1'b0;
                  load_tx = 1'b1;
               end else if (SCAN_GAP == 0) begin
                  state_d = CS_SETUP;
                  idx_d   = 2'd0;
                  cs_n_d  = 1'b0;
                  load_tx = 1'b1;
               end else begin
                  state_d = GAP;
               end
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               idx_d = 2'd0;
               if (enable) begin
                  state_d = CS_SETUP;
                  cs_n_d  = 1'b0;
                  load_tx = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_tx) begin
         tx_d   = tx_word(idx_d);
         mosi_d = tx_d[23];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         idx_q        <= '0;
         tx_q         <= '0;
         rx_q         <= '0;
         cs_n_q       <= 1'b1;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         sen_1_q      <= '0;
         sen_2_q      <= '0;
         sen_3_q      <= '0;
         scan_done_q  <= 1'b0;
         scan_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         idx_q        <= idx_d;
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         cs_n_q       <= cs_n_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         sen_1_q      <= sen_1_d;
         sen_2_q      <= sen_2_d;
         sen_3_q      <= sen_3_d;
         scan_done_q  <= scan_done_d;
         scan_count_q <= scan_count_d;
      end
   end

   assign cs_n       = cs_n_q;
   assign sclk       = sclk_q;
   assign mosi       = mosi_q;
   assign sen_1      = sen_1_q;
   assign sen_2      = sen_2_q;
   assign sen_3      = sen_3_q;
   assign scan_done  = scan_done_q;
   assign scan_count = scan_count_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_adc_reader.sv
// Directed bench for sensor_adc_reader: one DUT at CLK_DIV=2/SCAN_GAP=4 with
// an ADC model, a second at CLK_DIV=1/SCAN_GAP=0 for back-to-back scanning.
`timescale 1ns/1ps
module tb_sensor_adc_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, enable, enable0;
   logic        miso = 1'b0;
   logic        miso0 = 1'b0;
   logic        cs_n, sclk, mosi, scan_done, busy;
   logic [15:0] sen_1, sen_2, sen_3;
   logic [7:0]  scan_count;
   logic        cs_n0, sclk0, mosi0, scan_done0, busy0;
   logic [15:0] sen_10, sen_20, sen_30;
   logic [7:0]  scan_count0;

   int checks = 0;
   int failures = 0;

   sensor_adc_reader #(.CLK_DIV(2), .SCAN_GAP(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .miso(miso),
      .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
      .sen_1(sen_1), .sen_2(sen_2), .sen_3(sen_3),
      .scan_done(scan_done), .busy(busy), .scan_count(scan_count)
   );

   sensor_adc_reader #(.CLK_DIV(1), .SCAN_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .enable(enable0), .miso(miso0),
      .cs_n(cs_n0), .sclk(sclk0), .mosi(mosi0),
      .sen_1(sen_10), .sen_2(sen_20), .sen_3(sen_30),
      .scan_done(scan_done0), .busy(busy0), .scan_count(scan_count0)
   );

   // ADC model: decodes the channel from the command and returns its 10-bit value in the last 10 slots
   logic [9:0]  adc_val [8];
   int          adc_n = 0;
   logic [23:0] adc_cmd = '0;
   logic [2:0]  adc_ch = '0;
   always @(posedge sclk or negedge cs_n) begin
      if (sclk) begin
         adc_cmd = {adc_cmd[22:0], mosi};
         adc_n++;
         if (adc_n == 12) adc_ch = adc_cmd[2:0];
         if (adc_n >= 14 && adc_n <= 23) miso = adc_val[adc_ch][23 - adc_n];
         else miso = 1'b0;
      end else begin
         adc_n = 0;
         adc_cmd = '0;
         miso = 1'b0;
      end
   end

   // Frame monitor for the main DUT
   int          falls = 0, frames = 0, cur_len = 0, cur_rises = 0, pulses = 0, wide = 0;
   logic [23:0] cur_cmd = '0;
   int          frm_len [64];
   int          frm_rises [64];
   logic [23:0] frm_cmd [64];
   logic        cs_prev = 1'b1, sclk_prev = 1'b0, sd_prev = 1'b0;
   always @(negedge clk) begin
      if (cs_n === 1'b0 && cs_prev === 1'b1) begin
         falls++; cur_len = 0; cur_rises = 0; cur_cmd = '0;
      end
      if (cs_n === 1'b0) begin
         cur_len++;
         if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            cur_rises++; cur_cmd = {cur_cmd[22:0], mosi};
         end
      end
      if (cs_n === 1'b1 && cs_prev === 1'b0) begin
         frm_len[frames % 64] = cur_len;
         frm_rises[frames % 64] = cur_rises;
         frm_cmd[frames % 64] = cur_cmd;
         frames++;
      end
      if (scan_done === 1'b1) begin
         pulses++;
         if (sd_prev === 1'b1) wide++;
      end
      cs_prev = cs_n; sclk_prev = sclk; sd_prev = scan_done;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; enable0 = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; enable0 = 1'b0;
      tick(3);
      checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
      checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
      checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (scan_done !== 1'b0) begin failures++; $display("FAIL reset_scan_done got=%b exp=0", scan_done); end
      checks++; if (scan_count !== 8'd0) begin failures++; $display("FAIL reset_scan_count got=%0d exp=0", scan_count); end
      checks++; if ({sen_1, sen_2, sen_3} !== 48'd0) begin failures++; $display("FAIL reset_sen got=%h_%h_%h exp=0", sen_1, sen_2, sen_3); end
      checks++; if (cs_n0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL reset_dut0 got cs_n=%b busy=%b exp cs_n=1 busy=0", cs_n0, busy0); end
      rst = 1'b0;
      tick(10);
      checks++; if (busy !== 1'b0 || cs_n !== 1'b1) begin failures++; $display("FAIL idle_disabled got busy=%b cs_n=%b exp busy=0 cs_n=1", busy, cs_n); end
   endtask

   task automatic test_scan();
      int b_fr, b_p;
      bit found;
      adc_val[0] = 10'h3FF; adc_val[1] = 10'h155; adc_val[2] = 10'h001;
      do_reset();
      b_fr = frames; b_p = pulses; found = 0;
      enable = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (scan_done === 1'b1) begin found = 1; break; end
      end
      checks++; if (!found) begin failures++; $display("FAIL scan_timeout got=no_scan_done exp=scan_done"); end
      checks++; if (sen_1 !== 16'h03FF) begin failures++; $display("FAIL scan_sen_1 got=%h exp=03ff", sen_1); end
      checks++; if (sen_2 !== 16'h0155) begin failures++; $display("FAIL scan_sen_2 got=%h exp=0155", sen_2); end
      checks++; if (sen_3 !== 16'h0001) begin failures++; $display("FAIL scan_sen_3 got=%h exp=0001", sen_3); end
      checks++; if (scan_count !== 8'd1) begin failures++; $display("FAIL scan_count got=%0d exp=1", scan_count); end
      enable = 1'b0;
      tick(20);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL scan_stop_busy got=%b exp=0", busy); end
      checks++; if (pulses - b_p != 1) begin failures++; $display("FAIL scan_pulses got=%0d exp=1", pulses - b_p); end
      checks++; if (frames - b_fr != 3) begin failures++; $display("FAIL scan_frames got=%0d exp=3", frames - b_fr); end
      for (int k = 0; k < 3; k++) begin
         logic [23:0] exp_cmd;
         exp_cmd = 24'h018000 | (24'(k) << 12);
         checks++; if (frm_len[(b_fr + k) % 64] != 98) begin failures++; $display("FAIL frame%0d_cs_low got=%0d exp=98", k, frm_len[(b_fr + k) % 64]); end
         checks++; if (frm_rises[(b_fr + k) % 64] != 24) begin failures++; $display("FAIL frame%0d_sclk_rises got=%0d exp=24", k, frm_rises[(b_fr + k) % 64]); end
         checks++; if (frm_cmd[(b_fr + k) % 64] !== exp_cmd) begin failures++; $display("FAIL frame%0d_mosi got=%h exp=%h", k, frm_cmd[(b_fr + k) % 64], exp_cmd); end
      end
      tick(60);
      checks++; if ({sen_1, sen_2, sen_3} !== {16'h03FF, 16'h0155, 16'h0001}) begin failures++; $display("FAIL idle_hold got=%h_%h_%h exp=03ff_0155_0001", sen_1, sen_2, sen_3); end
      checks++; if (cs_n !== 1'b1 || sclk !== 1'b0) begin failures++; $display("FAIL idle_pins got cs_n=%b sclk=%b exp cs_n=1 sclk=0", cs_n, sclk); end
   endtask

   task automatic test_enable_drop();
      int b_fall, b_fr, b_p;
      bit hit, idle;
      adc_val[0] = 10'h2AA; adc_val[1] = 10'h0F0; adc_val[2] = 10'h3C3;
      do_reset();
      b_fall = falls; b_fr = frames; b_p = pulses; hit = 0; idle = 0;
      enable = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (falls - b_fall == 2 && cur_len == 20) begin hit = 1; break; end
      end
      enable = 1'b0;
      checks++; if (!hit) begin failures++; $display("FAIL drop_reach_frame2 got=not_reached exp=reached"); end
      for (int i = 0; i < 500; i++) begin
         tick(1);
         if (busy === 1'b0) begin idle = 1; break; end
      end
      checks++; if (!idle) begin failures++; $display("FAIL drop_idle_timeout got=busy exp=idle"); end
      checks++; if (sen_1 !== 16'h02AA) begin failures++; $display("FAIL drop_sen_1 got=%h exp=02aa", sen_1); end
      checks++; if (sen_2 !== 16'h00F0) begin failures++; $display("FAIL drop_sen_2 got=%h exp=00f0", sen_2); end
      checks++; if (sen_3 !== 16'h0000) begin failures++; $display("FAIL drop_sen_3 got=%h exp=0000", sen_3); end
      checks++; if (pulses - b_p != 0 || scan_count !== 8'd0) begin failures++; $display("FAIL drop_no_scan_done got pulses=%0d count=%0d exp 0 0", pulses - b_p, scan_count); end
      tick(300);
      checks++; if (falls - b_fall != 2 || frames - b_fr != 2) begin failures++; $display("FAIL drop_no_frame3 got falls=%0d frames=%0d exp 2 2", falls - b_fall, frames - b_fr); end
      checks++; if (sen_2 !== 16'h00F0 || busy !== 1'b0) begin failures++; $display("FAIL drop_hold got sen_2=%h busy=%b exp 00f0 0", sen_2, busy); end
   endtask

   task automatic test_reset_mid();
      int b_fall;
      bit hit;
      adc_val[0] = 10'h3FF; adc_val[1] = 10'h155; adc_val[2] = 10'h001;
      do_reset();
      b_fall = falls; hit = 0;
      enable = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (falls - b_fall == 2 && cur_rises == 10) begin hit = 1; break; end
      end
      checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach got=not_reached exp=reached"); end
      checks++; if (sen_1 !== 16'h03FF || sen_2 !== 16'h0000) begin failures++; $display("FAIL rstmid_before got sen_1=%h sen_2=%h exp 03ff 0000", sen_1, sen_2); end
      rst = 1'b1;
      tick(1);
      checks++; if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin failures++; $display("FAIL rstmid_pins got cs_n=%b sclk=%b mosi=%b exp 1 0 0", cs_n, sclk, mosi); end
      checks++; if ({sen_1, sen_2, sen_3} !== 48'd0) begin failures++; $display("FAIL rstmid_sen got=%h_%h_%h exp=0", sen_1, sen_2, sen_3); end
      checks++; if (scan_count !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_state got count=%0d busy=%b exp 0 0", scan_count, busy); end
      enable = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(200);
      checks++; if (sen_2 !== 16'h0000 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_after got sen_2=%h busy=%b exp 0000 0", sen_2, busy); end
   endtask

   task automatic test_back_to_back_wrap();
      int n0, wide0, hi_run, lo_run, bad_hi, bad_lo, frames0;
      logic [7:0] c1, c255, c256;
      logic prev_cs, prev_sd;
      n0 = 0; wide0 = 0; hi_run = 0; lo_run = 0; bad_hi = 0; bad_lo = 0; frames0 = 0;
      c1 = 8'hAA; c255 = 8'hAA; c256 = 8'hAA;
      prev_cs = 1'b1; prev_sd = 1'b0;
      do_reset();
      enable0 = 1'b1;
      for (int i = 0; i < 45000 && n0 < 256; i++) begin
         tick(1);
         if (scan_done0 === 1'b1) begin
            n0++;
            if (prev_sd) wide0++;
            if (n0 == 1) c1 = scan_count0;
            if (n0 == 255) c255 = scan_count0;
            if (n0 == 256) c256 = scan_count0;
         end
         if (cs_n0 === 1'b1) begin
            if (!prev_cs) begin frames0++; if (lo_run != 49) bad_lo++; hi_run = 0; end
            hi_run++;
         end else begin
            if (prev_cs) begin if (frames0 > 0 && hi_run != 1) bad_hi++; lo_run = 0; end
            lo_run++;
         end
         prev_cs = cs_n0; prev_sd = scan_done0;
      end
      enable0 = 1'b0;
      checks++; if (n0 != 256) begin failures++; $display("FAIL wrap_pulses got=%0d exp=256", n0); end
      checks++; if (wide0 != 0) begin failures++; $display("FAIL wrap_pulse_width got=%0d_wide exp=0_wide", wide0); end
      checks++; if (c1 !== 8'd1) begin failures++; $display("FAIL wrap_count_first got=%0d exp=1", c1); end
      checks++; if (c255 !== 8'd255) begin failures++; $display("FAIL wrap_count_255 got=%0d exp=255", c255); end
      checks++; if (c256 !== 8'd0) begin failures++; $display("FAIL wrap_count_256 got=%0d exp=0", c256); end
      checks++; if (frames0 != 768) begin failures++; $display("FAIL wrap_frames got=%0d exp=768", frames0); end
      checks++; if (bad_hi != 0) begin failures++; $display("FAIL gap0_cs_high got=%0d_bad_gaps exp=0", bad_hi); end
      checks++; if (bad_lo != 0) begin failures++; $display("FAIL gap0_cs_low got=%0d_bad_frames exp=0", bad_lo); end
      tick(10);
      checks++; if (busy0 !== 1'b0 || cs_n0 !== 1'b1) begin failures++; $display("FAIL wrap_stop got busy=%b cs_n=%b exp 0 1", busy0, cs_n0); end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) adc_val[i] = '0;
      rst = 1'b1; enable = 1'b0; enable0 = 1'b0;
      test_reset();
      test_scan();
      test_enable_drop();
      test_reset_mid();
      test_back_to_back_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sensor_adc_reader.md
SENSOR_ADC_READER -- requirements
Module: sensor_adc_reader

Interface
REQ-001 Parameter CLK_DIV, default 25: system clocks per SCLK half-period; legal range 1..255.
REQ-002 Parameter SCAN_GAP, default 1000: idle clocks between scans, cs_n high; legal range 0..2^20-1.
REQ-003 Parameters CH1/CH2/CH3, defaults 0/1/2: 3-bit ADC channel numbers feeding sen_1/sen_2/sen_3.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port enable, input, 1: scanning permitted while high.
REQ-007 Port miso, input, 1: ADC serial data out.
REQ-008 Port cs_n, output, 1: ADC chip select, active low.
REQ-009 Port sclk, output, 1: SPI clock, idle low.
REQ-010 Port mosi, output, 1: ADC serial command in.
REQ-011 Ports sen_1/sen_2/sen_3, output, 16 each: latest conversion per channel, zero-extended; feeds the per-sensor relay FSM inputs.
REQ-012 Port scan_done, output, 1: one-cycle pulse when all three sen values have been refreshed.
REQ-013 Port busy, output, 1: high whenever state is not IDLE.
REQ-014 Port scan_count, output, 8: completed-scan counter.

Function
REQ-015 States IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP; one-hot or binary at implementer's choice.
REQ-016 IDLE: cs_n=1, sclk=0, mosi=0; enable=1 -> CS_SETUP with channel index 0, cs_n=0 on the next cycle.
REQ-017 Tx word per frame, 24 bits, MSB first: {7'b0, 1'b1 start, 1'b1 single-ended, ch[2:0], 12'b0}.
REQ-018 CS_SETUP: CLK_DIV cycles, cs_n=0, sclk=0, mosi=tx bit 23.
REQ-019 SHIFT: 24 bits; each bit = sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-020 miso sampled on the clk edge that drives sclk 0->1, shifted into a 24-bit register MSB first.
REQ-021 mosi advances to the next tx bit on the clk edge that drives sclk 1->0.
REQ-022 After the 24th low phase: cs_n=1, sclk=0, go to CS_HOLD; cs_n low for exactly 49*CLK_DIV clocks per frame.
REQ-023 Result = rx[9:0] zero-extended to 16 bits; written into sen_(index+1) on the same edge cs_n rises; other sen_x unchanged.
REQ-024 CS_HOLD: CLK_DIV cycles, cs_n=1; then next index -> CS_SETUP if index<2, else GAP.
REQ-025 scan_done pulses and scan_count increments (8-bit wrap, 255->0) on the edge sen_3 is written.
REQ-026 GAP: SCAN_GAP cycles, cs_n=1; then CS_SETUP with index 0 if enable=1, else IDLE. SCAN_GAP=0 -> GAP lasts 0 cycles.
REQ-027 enable falling mid-frame: current frame completes and its result is stored; at CS_HOLD exit go to IDLE, index reset to 0; no scan_done for partial scans.
REQ-028 enable sampled only in IDLE, at CS_HOLD exit and at GAP exit.
REQ-029 sen_x hold their value indefinitely while IDLE.

Reset
REQ-030 rst=1 at any clk edge, including mid-frame: next cycle state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, scan_done=0, scan_count=0, sen_1..3=0, index=0, all counters cleared.
REQ-031 A partial frame interrupted by reset shall not update any sen_x.

Verification
REQ-032 CLK_DIV=2, SCAN_GAP=4, enable=1, ADC model returns 10'h3FF/10'h155/10'h001 on ch0/1/2 -> sen_1=16'h03FF, sen_2=16'h0155, sen_3=16'h0001, one scan_done pulse, scan_count=1.
REQ-033 CLK_DIV=2, check one frame -> cs_n low exactly 98 clocks, 24 sclk rising edges, mosi bits match {7'b0,1,1,3'b001,12'b0} for CH2.
REQ-034 rst asserted at the 10th sclk rising edge of frame 2 -> next cycle cs_n=1, sclk=0, all sen=0, scan_count=0; sen_2 never updated.
REQ-035 enable dropped during frame 2 -> frame 2 completes, sen_2 updated, no frame 3, IDLE, busy=0, no scan_done.
REQ-036 256 consecutive scans -> scan_count wraps to 0, 256 scan_done pulses, each exactly one clk wide.
REQ-037 SCAN_GAP=0 -> cs_n high exactly CLK_DIV clocks between sen_3 frame and the next sen_1 frame.
